// File: rtl/rsdec_pkg.sv
// Shared definitions for the RS(255,239) Berlekamp-Massey control path.
// GF(2^8) arithmetic uses field polynomial x^8+x^4+x^3+x^2+1 (0x11D).
package rsdec_pkg;

  localparam int GF_W = 8;
  localparam logic [8:0] GF_POLY = 9'h11D;
  localparam int NSYN = 16;
  localparam int T = 8;
  localparam int NPH = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Shift-and-add GF(2^8) multiply, same reduction as the datapath multiplier.
  function automatic logic [GF_W-1:0] gf_mul(input logic [GF_W-1:0] a,
                                             input logic [GF_W-1:0] b);
    logic [GF_W-1:0] p;
    logic [GF_W-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < GF_W; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[GF_W-2:0], 1'b0} ^ (x[GF_W-1] ? GF_POLY[GF_W-1:0] : '0);
    end
    return p;
  endfunction

endpackage

// File: rtl/rsdec_gf_inv.sv
// Combinational GF(2^8) inverse as d^254 (d^2 * d^4 * ... * d^128).
// A zero input yields zero, so inv(00) = 00 without a special case.
module rsdec_gf_inv
  import rsdec_pkg::*;
(
  input  logic [GF_W-1:0] d,
  output logic [GF_W-1:0] inv
);

  logic [GF_W-1:0] sq;
  logic [GF_W-1:0] acc;

  always_comb begin
    sq  = d;
    acc = 8'h01;
    for (int i = 1; i < GF_W; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    inv = acc;
  end

endmodule

// File: rtl/rsdec_berl_ctrl.sv
// Berlekamp-Massey sequencer: 16 iterations of 17 phases, then a 16-cycle drain.
// start to done is 289 cycles; start is ignored outside IDLE.
module rsdec_berl_ctrl
  import rsdec_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic [GF_W-1:0] D,
  output logic            enable,
  output logic            phase0,
  output logic            phase16,
  output logic [5:0]      count,
  output logic [GF_W-1:0] DI,
  output logic [4:0]      L,
  output logic            busy,
  output logic            out_valid,
  output logic [3:0]      out_idx,
  output logic            done,
  output logic            fail
);

  localparam logic [4:0] PH_LAST  = 5'(NPH - 1);
  localparam logic [5:0] CNT_LAST = 6'(NSYN - 1);
  localparam logic [3:0] IDX_TOP  = 4'(NSYN - 1);
  localparam logic [4:0] L_MAX    = 5'(T);

  state_t          state;
  logic [4:0]      ph;
  logic [GF_W-1:0] pend;
  logic [GF_W-1:0] d_inv;
  logic            accept;
  logic [5:0]      l_next;

  rsdec_gf_inv u_inv (
    .d  (D),
    .inv(d_inv)
  );

  // Length change rule: nonzero discrepancy and i >= 2L gives L' = i - L + 1.
  assign accept = (D != 8'h00) && (count >= {L, 1'b0});
  assign l_next = count - {1'b0, L} + 6'd1;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= ST_IDLE;
      ph        <= '0;
      pend      <= 8'h01;
      enable    <= 1'b0;
      phase0    <= 1'b0;
      phase16   <= 1'b0;
      count     <= '0;
      DI        <= 8'h01;
      L         <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      done      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          enable <= 1'b0;
          done   <= 1'b0;
          if (start) begin
            state   <= ST_RUN;
            ph      <= '0;
            count   <= '0;
            L       <= '0;
            DI      <= 8'h01;
            pend    <= 8'h01;
            fail    <= 1'b0;
            enable  <= 1'b1;
            phase0  <= 1'b1;
            phase16 <= 1'b0;
            busy    <= 1'b1;
          end
        end

        ST_RUN: begin
          if (ph == 5'd1 && accept) begin
            L    <= l_next[4:0];
            pend <= d_inv;
          end
          if (ph == PH_LAST) begin
            ph <= '0;
            if (count == CNT_LAST) begin
              // Unit DI lets the datapath pass raw coefficients out.
              state     <= ST_DRAIN;
              phase0    <= 1'b0;
              phase16   <= 1'b1;
              DI        <= 8'h01;
              out_valid <= 1'b1;
              out_idx   <= IDX_TOP;
            end else begin
              count   <= count + 6'd1;
              DI      <= pend;
              phase0  <= 1'b1;
              phase16 <= 1'b0;
            end
          end else begin
            ph      <= ph + 5'd1;
            phase0  <= 1'b0;
            phase16 <= ((ph + 5'd1) == PH_LAST);
          end
        end

        ST_DRAIN: begin
          if (out_idx == 4'd0) begin
            state     <= ST_DONE;
            done      <= 1'b1;
            fail      <= (L > L_MAX);
            busy      <= 1'b0;
            enable    <= 1'b0;
            phase16   <= 1'b0;
            out_valid <= 1'b0;
          end else begin
            out_idx <= out_idx - 4'd1;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsdec_berl_ctrl.sv
// Directed bench for rsdec_berl_ctrl: table of discrepancy patterns plus reset/stray-start sequences.
module tb_rsdec_berl_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [7:0]  D;
  logic        enable;
  logic        phase0;
  logic        phase16;
  logic [5:0]  count;
  logic [7:0]  DI;
  logic [4:0]  L;
  logic        busy;
  logic        out_valid;
  logic [3:0]  out_idx;
  logic        done;
  logic        fail;

  always #5 clk = ~clk;

  rsdec_berl_ctrl dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .D        (D),
    .enable   (enable),
    .phase0   (phase0),
    .phase16  (phase16),
    .count    (count),
    .DI       (DI),
    .L        (L),
    .busy     (busy),
    .out_valid(out_valid),
    .out_idx  (out_idx),
    .done     (done),
    .fail     (fail)
  );

  typedef struct {
    logic [15:0][7:0] dv;
    logic [4:0]       exp_l;
    logic             exp_fail;
    logic [7:0]       exp_di1;
    logic [7:0]       exp_di15;
  } vec_t;

  vec_t             tab[5];
  logic [15:0][7:0] dvec;
  int               n_pass = 0;
  int               n_total = 0;
  string            tag = "";

  // Datapath stand-in: discrepancy per iteration index.
  always_comb D = dvec[count[3:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s%s: got %0h expected %0h", tag, name, act, exp);
  endtask

  task automatic check_reset(input string t);
    chk({t, "_enable"},    32'(enable),    32'd0);
    chk({t, "_phase0"},    32'(phase0),    32'd0);
    chk({t, "_phase16"},   32'(phase16),   32'd0);
    chk({t, "_count"},     32'(count),     32'd0);
    chk({t, "_DI"},        32'(DI),        32'h01);
    chk({t, "_L"},         32'(L),         32'd0);
    chk({t, "_busy"},      32'(busy),      32'd0);
    chk({t, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({t, "_out_idx"},   32'(out_idx),   32'd0);
    chk({t, "_done"},      32'(done),      32'd0);
    chk({t, "_fail"},      32'(fail),      32'd0);
  endtask

  // Called #1 after a posedge; returns #1 after the edge following done.
  task automatic run_vec(input int vi, input bit stray);
    int         done_n, drain_first, drain_n, p0_n, p16_n;
    int         seq_err, idx_err, drain_err;
    logic [7:0] di1, di15;
    logic [3:0] exp_idx;
    logic       fail_at1, busy_at1;
    tag = $sformatf("v%0d_", vi);
    dvec = tab[vi].dv;
    done_n = 0; drain_first = 0; drain_n = 0; p0_n = 0; p16_n = 0;
    seq_err = 0; idx_err = 0; drain_err = 0;
    di1 = 8'h00; di15 = 8'h00; exp_idx = 4'd15;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fail_at1 = fail;
    busy_at1 = busy;
    for (int n = 1; n <= 400 && done_n == 0; n++) begin
      if (n > 1) begin
        @(posedge clk); #1;
      end
      if (stray) start = (n == 100 || n == 280);
      if (phase0) begin
        if (count != 6'(p0_n)) seq_err++;
        if (count == 6'd1) di1 = DI;
        if (count == 6'd15) di15 = DI;
        p0_n++;
      end
      if (phase16) p16_n++;
      if (out_valid) begin
        if (drain_n == 0) drain_first = n;
        if (out_idx != exp_idx) idx_err++;
        if (DI != 8'h01 || count != 6'd15 || !enable || phase0 || !phase16 || !busy) drain_err++;
        exp_idx = exp_idx - 4'd1;
        drain_n++;
      end
      if (done) done_n = n;
    end
    start = 1'b0;
    chk("busy_run",     32'(busy_at1),    32'd1);
    chk("fail_cleared", 32'(fail_at1),    32'd0);
    chk("done_cycle",   32'(done_n),      32'd289);
    chk("drain_start",  32'(drain_first), 32'd273);
    chk("drain_len",    32'(drain_n),     32'd16);
    chk("out_idx_seq",  32'(idx_err),     32'd0);
    chk("drain_ctl",    32'(drain_err),   32'd0);
    chk("phase0_cnt",   32'(p0_n),        32'd16);
    chk("phase16_cnt",  32'(p16_n),       32'd32);
    chk("count_seq",    32'(seq_err),     32'd0);
    chk("DI_iter1",     32'(di1),         32'(tab[vi].exp_di1));
    chk("DI_iter15",    32'(di15),        32'(tab[vi].exp_di15));
    chk("L_final",      32'(L),           32'(tab[vi].exp_l));
    chk("fail",         32'(fail),        32'(tab[vi].exp_fail));
    chk("busy_done",    32'(busy),        32'd0);
    @(posedge clk); #1;
    chk("done_pulse",   32'(done),        32'd0);
    chk("fail_hold",    32'(fail),        32'(tab[vi].exp_fail));
    chk("L_hold",       32'(L),           32'(tab[vi].exp_l));
    chk("enable_idle",  32'(enable),      32'd0);
  endtask

  initial begin
    // All-zero syndromes: nothing accepted.
    tab[0].dv = '0;
    tab[0].exp_l = 5'd0; tab[0].exp_fail = 1'b0; tab[0].exp_di1 = 8'h01; tab[0].exp_di15 = 8'h01;
    // Single discrepancy 02 at i=0: L=1, DI = inv(02) = 8E from iteration 1.
    tab[1].dv = '0; tab[1].dv[0] = 8'h02;
    tab[1].exp_l = 5'd1; tab[1].exp_fail = 1'b0; tab[1].exp_di1 = 8'h8E; tab[1].exp_di15 = 8'h8E;
    // D=01 every iteration: L steps 1,2,...,8 at i=0,2,...,14; L==T is not a failure.
    tab[2].dv = {16{8'h01}};
    tab[2].exp_l = 5'd8; tab[2].exp_fail = 1'b0; tab[2].exp_di1 = 8'h01; tab[2].exp_di15 = 8'h01;
    // Only i=8 nonzero (8E): L jumps 0 -> 9 > T, DI = inv(8E) = 02.
    tab[3].dv = '0; tab[3].dv[8] = 8'h8E;
    tab[3].exp_l = 5'd9; tab[3].exp_fail = 1'b1; tab[3].exp_di1 = 8'h01; tab[3].exp_di15 = 8'h02;
    // i=0 accepted (L=1), i=1 rejected (1 < 2), i=2 accepted at equality (L=2, DI=02).
    tab[4].dv = '0; tab[4].dv[0] = 8'h02; tab[4].dv[1] = 8'h55; tab[4].dv[2] = 8'h8E;
    tab[4].exp_l = 5'd2; tab[4].exp_fail = 1'b0; tab[4].exp_di1 = 8'h8E; tab[4].exp_di15 = 8'h02;

    dvec  = '0;
    clr   = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    clr = 1'b0;
    @(posedge clk); #1;

    // Back-to-back: each run starts the cycle after the previous done.
    for (int i = 0; i < 5; i++) run_vec(i, (i == 1));

    // Asynchronous clear at iteration 7, phase 5 (cycle 1 + 7*17 + 5).
    tag = "clr_";
    dvec = tab[1].dv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (124) @(posedge clk);
    #1;
    chk("pre_count", 32'(count), 32'd7);
    chk("pre_DI",    32'(DI),    32'h8E);
    chk("pre_L",     32'(L),     32'd1);
    #2 clr = 1'b1;
    #1;
    check_reset("midclr");
    @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;
    run_vec(2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
